shift_sequencer: RTL
====================

// Module: shift_sequencer
// PURPOSE
//   Multi-cycle controller for the 32-bit logarithmic shift datapath (5 levels: 1,2,4,8,16).
//   Accepts one shift op at a time via valid/ready and runs LEVELS_PER_CYCLE mux levels per clock.
//   Supports SLL, SRL and SRA. Returns a registered result through a valid/ready output handshake.
//   Sits beside the ALU and feeds the result mux of the midterm datapath.
// PARAMETERS
//   LEVELS_PER_CYCLE  1     shift levels evaluated per clock; legal 1..5, other values are illegal
//   N_CYC             derived, ceil(5/LEVELS_PER_CYCLE); number of SHIFT cycles (localparam)
// PORTS
//   clk        in   1   clock, rising edge
//   reset      in   1   asynchronous, active-low reset
//   in_valid   in   1   request present
//   in_ready   out  1   block can accept a request (high only in IDLE)
//   dataA      in   32  operand to shift
//   dataB      in   32  shift amount; only dataB[4:0] used, bits [31:5] ignored
//   Signal     in   6   op: SLL=6'b000000, SRL=6'b000010, SRA=6'b000011
//   out_valid  out  1   result valid
//   out_ready  in   1   consumer takes result
//   dataOut    out  32  registered result
//   bad_op     out  1   qualifies out_valid: Signal was unsupported
//   busy       out  1   state != IDLE
// BEHAVIOUR
//   Reset (reset==0, async): state=IDLE, level counter=0, dataOut=0, out_valid=0, bad_op=0, busy=0.
//     Reset mid-operation aborts the op; no result is ever presented for it.
//   FSM states: IDLE, SHIFT, DONE.
//   IDLE: in_ready=1. On in_valid at edge E, latch dataA, shamt=dataB[4:0], Signal, sign=dataA[31].
//     If Signal is legal: go to SHIFT with lvl=0.
//     If Signal is not legal: go to DONE with dataOut=0 and bad_op=1.
//   SHIFT: each cycle apply levels k=lvl..min(lvl+LEVELS_PER_CYCLE,5)-1 in ascending order.
//     A level shifts by 2^k only if shamt[k]=1.
//     SRL fills with 0; SRA fills with the latched sign; SLL shifts left and fills with 0.
//     lvl += LEVELS_PER_CYCLE. On the last SHIFT cycle, go to DONE with bad_op=0.
//   Latency is fixed: out_valid rises after edge E+N_CYC, independent of shamt (shamt=0 included).
//   DONE: out_valid=1. dataOut and bad_op stay stable until out_ready=1.
//     On the edge where out_ready=1: go to IDLE, out_valid=0. dataOut keeps its last value.
//   in_ready=0 in SHIFT and DONE; in_valid is ignored there (no queuing, no back-to-back accept from DONE).
//   Changes to dataA, dataB and Signal after acceptance have no effect on the op in flight.
//   Width rules: all arithmetic is 32-bit; level counter is 3 bits; shamt bits above 4 never affect the result.
// TESTING
//   LPC=1, SRL A=32'h80000000 dataB=31
//     -> dataOut=32'h00000001, out_valid exactly 5 cycles after accept, bad_op=0.
//   SRA A=32'hF0000000 dataB=4 -> 32'hFF000000; SLL A=32'h00000001 dataB=31 -> 32'h80000000.
//   SRL A=32'h12345678 dataB=32'hFFFFFFE0 (shamt 0) -> dataOut=32'h12345678, same 5-cycle latency.
//   Hold out_ready=0 for 3 cycles in DONE, pulse in_valid during the wait
//     -> out_valid/dataOut held, in_ready=0, new request not accepted.
//   Signal=6'b100000 -> out_valid one cycle after accept, bad_op=1, dataOut=0.
//   Drop reset in SHIFT -> out_valid=0, dataOut=0, busy=0 immediately (async).
//     Next SLL A=1 dataB=3 -> 32'h00000008.
//   Repeat the first two cases with LPC=5 -> result 1 cycle after accept; with LPC=2 -> 3 cycles.

Source files
------------

// File: rtl/shift_sequencer.sv
// Multi-cycle controller for the 32-bit logarithmic shifter (levels 1,2,4,8,16).
// Evaluates LEVELS_PER_CYCLE mux levels per clock (legal 1..5) behind valid/ready handshakes.

module shift_stage (
    input  logic [31:0] d,
    input  logic [2:0]  k,
    input  logic        en,
    input  logic [1:0]  op,
    input  logic        sign,
    output logic [31:0] q
);
    logic [4:0]  amt;
    logic [31:0] fill;

    always_comb begin
        amt  = 5'd1 << k;
        fill = ~(32'hFFFF_FFFF >> amt);
        q    = d;
        if (en) begin
            case (op)
                2'b00:   q = d << amt;
                2'b11:   q = (d >> amt) | (sign ? fill : 32'h0);
                default: q = d >> amt;
            endcase
        end
    end
endmodule

module shift_sequencer #(
    parameter int LEVELS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] dataA,
    input  logic [31:0] dataB,
    input  logic [5:0]  Signal,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] dataOut,
    output logic        bad_op,
    output logic        busy
);
    localparam int LPC   = LEVELS_PER_CYCLE;
    localparam int N_CYC = (5 + LPC - 1) / LPC;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state;
    logic [2:0]  lvl;
    logic [31:0] a_q;
    logic [4:0]  shamt_q;
    logic [1:0]  op_q;
    logic        sign_q;
    logic        legal;
    logic        last;
    logic [7:0]  shamt_x;

    logic [LPC:0][31:0] chain;

    assign legal    = (Signal == 6'b000000) || (Signal == 6'b000010) || (Signal == 6'b000011);
    assign last     = ({1'b0, lvl} + 4'(LPC)) >= 4'd5;
    // Zero-extended so level indices past 4 (partial last cycle) read as "no shift".
    assign shamt_x  = {3'b000, shamt_q};
    assign chain[0] = a_q;
    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    genvar j;
    generate
        for (j = 0; j < LPC; j++) begin : g_lvl
            logic [2:0] k;
            assign k = lvl + 3'(j);
            shift_stage u_stage (
                .d    (chain[j]),
                .k    (k),
                .en   (shamt_x[k]),
                .op   (op_q),
                .sign (sign_q),
                .q    (chain[j+1])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            lvl       <= 3'd0;
            a_q       <= 32'h0;
            shamt_q   <= 5'd0;
            op_q      <= 2'b00;
            sign_q    <= 1'b0;
            dataOut   <= 32'h0;
            out_valid <= 1'b0;
            bad_op    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_q     <= dataA;
                    shamt_q <= dataB[4:0];
                    op_q    <= Signal[1:0];
                    sign_q  <= dataA[31];
                    lvl     <= 3'd0;
                    if (legal) begin
                        state <= SHIFT;
                    end else begin
                        state     <= DONE;
                        dataOut   <= 32'h0;
                        bad_op    <= 1'b1;
                        out_valid <= 1'b1;
                    end
                end
                SHIFT: begin
                    a_q <= chain[LPC];
                    lvl <= lvl + 3'(LPC);
                    if (last) begin
                        state     <= DONE;
                        lvl       <= 3'd0;
                        dataOut   <= chain[LPC];
                        bad_op    <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                DONE: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // N_CYC is the fixed SHIFT-cycle count; lvl stepping above realises it.
    logic [3:0] n_cyc_unused;
    assign n_cyc_unused = 4'(N_CYC);
endmodule
